// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: data width, the canonical NOP,
// and the record a fetched instruction travels in.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched instructions between the fetch and decode stages.
// Flush and reset both empty it; the data array itself needs no reset.
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = entries[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word requests to a 1-cycle
// synchronous instruction memory and feeds decode through a 2-entry buffer.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    input  logic            stall_d,
    output logic            valid_d,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d
);

    logic [XLEN-1:0] pc_f;
    logic            inflight_v;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] target_aligned;
    logic [1:0]      count;
    logic [2:0]      occupancy;
    logic            pop;
    logic            push;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    assign target_aligned = pc_target_e & ~32'h0000_0003;
    assign valid_d        = (count != 2'd0);
    assign pop            = valid_d && !stall_d;

    // A redirect kills the response of the previous request before it lands.
    assign push           = inflight_v && !pc_src_e;
    assign push_data      = '{instr: imem_rdata, pc: inflight_pc};

    // Requests are throttled so every response always has a buffer slot.
    assign occupancy = {1'b0, count} + {2'b00, inflight_v};

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_f;
        if (!rst) begin
            if (pc_src_e) begin
                imem_req  = 1'b1;
                imem_addr = target_aligned;
            end else begin
                imem_req  = (occupancy < (3'd2 + {2'b00, pop}));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f        <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight_v  <= imem_req;
            inflight_pc <= imem_addr;
            if (imem_req) begin
                pc_f <= imem_addr + 32'd4;
            end
        end
    end

    fetch_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (pc_src_e),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        instr_d    = NOP_INSTR;
        pc_d       = '0;
        pc_plus4_d = '0;
        if (valid_d) begin
            instr_d    = head.instr;
            pc_d       = head.pc;
            pc_plus4_d = head.pc + 32'd4;
        end
    end

endmodule
